q44_addsub_checker: RTL
=======================

# q44_addsub_checker

Self-checking hardware stimulus sequencer for the Q4.4 signed fixed-point add/subtract unit. On `start` it drives a fixed table of operand vectors into the unit's `a`/`b`/`sel` inputs and waits a programmable settle time. It then samples the unit's `result`/`overflow` and compares them against an internally computed golden value, counting passes and failures. It sits beside the adder on the FPGA test top, so the adder can be verified in silicon without a simulator.

## Interface
- `NUM_VECTORS`, default 8: number of table entries run, legal 1..8.
- `SETTLE_CYCLES`, default 1: cycles operands are held before sampling, legal 1..15.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, active-low. One clock; reset is asynchronous and active-low.
- `start`  in  1  run request, sampled in IDLE only.
- `dut_result`  in  8  Q4.4 result from the adder.
- `dut_overflow`  in  1  overflow flag from the adder.
- `a_out`  out  8  operand A to the adder (Q4.4, two's complement).
- `b_out`  out  8  operand B to the adder.
- `sel_out`  out  1  0 = add, 1 = subtract.
- `busy`  out  1  high from the start acceptance until `done`.
- `done`  out  1  one-cycle pulse at the end of a run.
- `pass_count`  out  4  matching vectors in the last run.
- `fail_count`  out  4  mismatching vectors in the last run.
- `first_fail_valid`  out  1  at least one mismatch in the last run.
- `first_fail_idx`  out  3  index of the first mismatching vector.

## Operation
- Vector table, fixed, entries (a, b, sel):
  - 0: 0x18, 0x08, 0
  - 1: 0x20, 0x08, 1
  - 2: 0x70, 0x40, 0
  - 3: 0x80, 0x10, 1
  - 4: 0xF0, 0x10, 0
  - 5: 0x7F, 0x01, 0
  - 6: 0x00, 0x80, 1
  - 7: 0xC8, 0xE8, 0
- Golden value:
  - `exp = sel ? a - b : a + b`, truncated to 8 bits.
  - For add, `exp_ovf = (a[7]==b[7]) && (exp[7]!=a[7])`.
  - For subtract, `exp_ovf = (a[7]!=b[7]) && (exp[7]!=a[7])`.
  - Expected (result, ovf) for entries 0..7: (0x20,0) (0x18,0) (0xB0,1) (0x70,1) (0x00,0) (0x80,1) (0x80,1) (0xB0,0).
- A vector passes only when both `dut_result==exp` and `dut_overflow==exp_ovf`.
- FSM states:
  - IDLE: `start` goes to DRIVE with index 0, and clears the counts and first-fail fields.
  - DRIVE: outputs the table entry and holds it for SETTLE_CYCLES cycles, then goes to CHECK.
  - CHECK: samples and compares, updates the counts, and records the first failure. If the index is NUM_VECTORS-1 it goes to DONE; otherwise it increments the index and returns to DRIVE.
  - DONE: pulses `done` and returns to IDLE.
- `start` while busy is ignored.
- Result outputs hold their values from the end of a run until the next accepted `start`.
- In IDLE, `a_out`/`b_out`/`sel_out` drive 0x00/0x00/0.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0: `busy`, `done`, counts, `first_fail_*`, `a_out`, `b_out`, `sel_out`.
- Reset asserted mid-run aborts the run immediately. Counts are lost and no `done` is produced.
- Cycle 0 is the edge that samples `start`=1 in IDLE.
  - `busy` and entry 0 appear after cycle 0.
  - Each vector occupies SETTLE_CYCLES+1 cycles: SETTLE_CYCLES in DRIVE plus 1 in CHECK. Operands remain stable through CHECK.
  - The comparison uses the inputs as sampled on the CHECK edge.
  - `done` is high for exactly one cycle, NUM_VECTORS×(SETTLE_CYCLES+1)+1 cycles after cycle 0. With defaults this is cycle 17.
  - `busy` falls on the same edge on which `done` falls.
- Counters are always final and stable while `done` is high.
- A `start` held high continuously starts a new run on the first IDLE cycle after DONE.

## Configuration
- `CHECKER_STOP_ON_FAIL_EN`:
  - Defined: the first mismatch in CHECK goes directly to DONE, skipping the remaining vectors. `pass_count + fail_count` equals the index of the failing vector plus 1.
  - Undefined: all NUM_VECTORS vectors always run, and the counts sum to NUM_VECTORS.

## Test plan
- Defaults, ideal behavioral adder connected, `start` pulsed: `done` at cycle 17, pass_count=8, fail_count=0, first_fail_valid=0, then IDLE with 0x00 operands.
- Adder model with `overflow` stuck at 0, macro undefined: fail_count=4 (vectors 2, 3, 5, 6), pass_count=4, first_fail_idx=2.
- Same stuck model, `CHECKER_STOP_ON_FAIL_EN` defined: `done` after vector 2 (cycle 7), pass_count=2, fail_count=1, first_fail_idx=2.
- SETTLE_CYCLES=3 with an adder model delayed 2 cycles: all pass, `done` at cycle 33. With SETTLE_CYCLES=1, the same model produces nonzero fail_count.
- `rst_n` pulsed low at cycle 6 of a run: all outputs return to 0 asynchronously, and no `done` is produced. A fresh `start` then completes with pass_count=8.
- `start` re-asserted at cycles 3 and 10 of a run: ignored, single `done` at cycle 17, counts unchanged from the ideal case.

Source files
------------

// File: rtl/q44_addsub_checker.sv
// ---------------------------------------------------------------------------
// q44_addsub_checker
//
// In-silicon stimulus sequencer and checker for a Q4.4 signed fixed-point
// add/subtract unit. On an accepted start, it steps through a fixed table of
// eight operand vectors. Each vector is held on a_out/b_out/sel_out for
// SETTLE_CYCLES cycles and then held for one CHECK cycle. On the edge that
// leaves CHECK, the checker samples the unit's result and overflow flag and
// compares them with a golden value computed here.
//
// Parameters
//   NUM_VECTORS    table entries run per pass, 1..8
//   SETTLE_CYCLES  cycles each vector is held before sampling, 1..15
//
// Ports
//   clk               in   system clock, rising edge
//   rst_n             in   asynchronous active-low reset
//   start             in   run request, honoured only while idle
//   dut_result[7:0]   in   Q4.4 result from the unit under test
//   dut_overflow      in   overflow flag from the unit under test
//   a_out[7:0]        out  operand A (0x00 while idle)
//   b_out[7:0]        out  operand B (0x00 while idle)
//   sel_out           out  0 = add, 1 = subtract (0 while idle)
//   busy              out  high from start acceptance until done falls
//   done              out  one-cycle pulse at the end of a run
//   pass_count[3:0]   out  matching vectors in the last run
//   fail_count[3:0]   out  mismatching vectors in the last run
//   first_fail_valid  out  at least one mismatch in the last run
//   first_fail_idx    out  table index of the first mismatch
//
// Build option
//   CHECKER_STOP_ON_FAIL_EN  when defined, the first mismatch ends the run
//                            immediately; otherwise every vector always runs.
// ---------------------------------------------------------------------------
module q44_addsub_checker #(
    parameter int NUM_VECTORS   = 8,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] dut_result,
    input  logic       dut_overflow,
    output logic [7:0] a_out,
    output logic [7:0] b_out,
    output logic       sel_out,
    output logic       busy,
    output logic       done,
    output logic [3:0] pass_count,
    output logic [3:0] fail_count,
    output logic       first_fail_valid,
    output logic [2:0] first_fail_idx
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_CHECK,
        S_DONE
    } state_e;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       sel;
    } vec_t;

    localparam logic [2:0] IDX_LAST    = 3'(NUM_VECTORS - 1);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    function automatic vec_t vec_entry(input logic [2:0] idx);
        vec_t v;
        case (idx)
            3'd0:    v = '{a: 8'h18, b: 8'h08, sel: 1'b0};
            3'd1:    v = '{a: 8'h20, b: 8'h08, sel: 1'b1};
            3'd2:    v = '{a: 8'h70, b: 8'h40, sel: 1'b0};
            3'd3:    v = '{a: 8'h80, b: 8'h10, sel: 1'b1};
            3'd4:    v = '{a: 8'hF0, b: 8'h10, sel: 1'b0};
            3'd5:    v = '{a: 8'h7F, b: 8'h01, sel: 1'b0};
            3'd6:    v = '{a: 8'h00, b: 8'h80, sel: 1'b1};
            default: v = '{a: 8'hC8, b: 8'hE8, sel: 1'b0};
        endcase
        return v;
    endfunction

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] settle_q, settle_d;
    logic [3:0] pass_q, pass_d;
    logic [3:0] fail_q, fail_d;
    logic       ffv_q, ffv_d;
    logic [2:0] ffi_q, ffi_d;

    vec_t       cur;
    logic [7:0] exp_res;
    logic       exp_ovf;
    logic       match;

    // Golden value for the vector currently on the operand bus. Signed
    // overflow shows up as a result sign that disagrees with A when the
    // effective operand signs agree (add: same signs, subtract: opposite).
    always_comb begin
        cur     = vec_entry(idx_q);
        exp_res = cur.sel ? (cur.a - cur.b) : (cur.a + cur.b);
        if (cur.sel) begin
            exp_ovf = (cur.a[7] != cur.b[7]) && (exp_res[7] != cur.a[7]);
        end else begin
            exp_ovf = (cur.a[7] == cur.b[7]) && (exp_res[7] != cur.a[7]);
        end
        match = (dut_result == exp_res) && (dut_overflow == exp_ovf);
    end

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // the case below can leave it unassigned and infer a latch.
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        pass_d   = pass_q;
        fail_d   = fail_q;
        ffv_d    = ffv_q;
        ffi_d    = ffi_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_DRIVE;
                    idx_d    = 3'd0;
                    settle_d = 4'd0;
                    pass_d   = 4'd0;
                    fail_d   = 4'd0;
                    ffv_d    = 1'b0;
                    ffi_d    = 3'd0;
                end
            end

            S_DRIVE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = S_CHECK;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end

            S_CHECK: begin
                settle_d = 4'd0;
                if (match) begin
                    pass_d = pass_q + 4'd1;
                end else begin
                    fail_d = fail_q + 4'd1;
                    if (!ffv_q) begin
                        ffv_d = 1'b1;
                        ffi_d = idx_q;
                    end
                end

                if (idx_q == IDX_LAST) begin
                    state_d = S_DONE;
                end
`ifdef CHECKER_STOP_ON_FAIL_EN
                else if (!match) begin
                    state_d = S_DONE;
                end
`endif
                else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = S_DRIVE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= 3'd0;
            settle_q <= 4'd0;
            pass_q   <= 4'd0;
            fail_q   <= 4'd0;
            ffv_q    <= 1'b0;
            ffi_q    <= 3'd0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            ffv_q    <= ffv_d;
            ffi_q    <= ffi_d;
        end
    end

    // Outputs decode directly from registered state, so an asynchronous
    // reset clears every output at once with no clock needed.
    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
        if ((state_q == S_DRIVE) || (state_q == S_CHECK)) begin
            a_out   = cur.a;
            b_out   = cur.b;
            sel_out = cur.sel;
        end else begin
            a_out   = 8'h00;
            b_out   = 8'h00;
            sel_out = 1'b0;
        end
        pass_count       = pass_q;
        fail_count       = fail_q;
        first_fail_valid = ffv_q;
        first_fail_idx   = ffi_q;
    end

endmodule
